spi_cmd_rx: RTL
===============

SPI_CMD_RX -- requirements
Module: spi_cmd_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, receive byte FIFO entries; power of two, 4..256.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops on each SPI input, minimum 2.
REQ-003 clk  input  1  system clock; all state on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 spi_sck  input  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0).
REQ-006 spi_cs_n  input  1  SPI chip select from host, active-low.
REQ-007 spi_mosi  input  1  host-to-device data, MSB first.
REQ-008 spi_miso  output  1  device-to-host data, MSB first.
REQ-009 tx_byte  input  8  byte to return on the next SPI byte; driven by the controller's spi_output.
REQ-010 in_byte  output  8  FIFO head byte, to the controller.
REQ-011 in_valid  output  1  FIFO non-empty; in_byte is meaningful.
REQ-012 next  input  1  pop strobe from the controller, one cycle per byte consumed.
REQ-013 overflow  output  1  sticky flag: a received byte was dropped.
REQ-014 rx_active  output  1  synchronized chip select asserted.
REQ-015 ovf_count  output  8  dropped-byte count (see Configuration).

Function
REQ-016 spi_sck, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops before any use; edges are detected on the synchronized values; clk frequency is at least 4x spi_sck frequency.
REQ-017 While synchronized cs_n is high, the 3-bit bit counter and the RX shift register are held at 0.
REQ-018 On each synchronized sck rising edge with cs_n low: mosi shifts into RX bit 0; the bit counter increments modulo 8.
REQ-019 On the rising edge that completes bit 8, the assembled byte is pushed into the FIFO in the same clk cycle.
REQ-020 When cs_n deasserts mid-byte, the partial byte is discarded and nothing is pushed.
REQ-021 in_byte and in_valid are registered from FIFO state: a push into an empty FIFO at cycle N gives in_valid=1 at cycle N+1.
REQ-022 A next pulse at cycle N pops the head; in_byte and in_valid reflect the new head at N+1.
REQ-023 next while the FIFO is empty is ignored, with no state change.
REQ-024 Push and pop in the same cycle are both performed, including when the FIFO is full; occupancy is unchanged.
REQ-025 Push when full without a same-cycle pop drops the byte, sets overflow, and leaves FIFO contents intact.
REQ-026 TX shift register loading:
- loads tx_byte on the synchronized cs_n falling edge;
- loads tx_byte again on each byte completion;
- spi_miso = TX bit 7;
- shifts left, filling with 0, on each synchronized sck falling edge with cs_n low.
REQ-027 spi_miso is 0 while cs_n is high.
REQ-028 The pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a counter of width clog2(FIFO_DEPTH)+1.

Reset
REQ-029 reset_n low asynchronously clears the following:
- FIFO pointers and occupancy;
- bit counter, RX and TX shift registers;
- synchronizer flops (cs_n stages to 1, others to 0);
- in_byte=0, in_valid=0, spi_miso=0, overflow=0, rx_active=0, ovf_count=0.
REQ-030 Reset asserted mid-transfer discards the partial byte; after release, reception resumes only after a fresh cs_n falling edge.

Configuration
REQ-031 With macro SPI_CMD_RX_OVF_COUNT_EN defined, ovf_count increments on each dropped byte and saturates at 255.
REQ-032 Without SPI_CMD_RX_OVF_COUNT_EN, ovf_count is constant 0, no counter logic is instantiated, and overflow behaves as specified.

Structure
REQ-033 A shared header spi.vh holds the following constants:
- default FIFO depth;
- synchronizer stage count;
- SPI byte width of 8.
REQ-034 FIFO storage and pointers are a sub-module named byte_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, empty, full, count).

Verification
REQ-035 Single byte: host sends 0xA5 under cs_n; no next → in_valid=1, in_byte=0xA5 within SYNC_STAGES+2 clk of the 8th sck rise.
REQ-036 Controller-style pop: bytes 0x10,0x20,0x30; next pulses one cycle after each in_valid → in_byte sequence 0x10,0x20,0x30, then in_valid=0.
REQ-037 Overflow: FIFO_DEPTH+2 bytes 0x00.. with no next → first FIFO_DEPTH bytes intact, overflow=1, ovf_count=2 (macro on) or 0 (macro off).
REQ-038 Abort: cs_n deasserted after 5 bits, then full byte 0x3C → only 0x3C is queued.
REQ-039 MISO: tx_byte=0xC3 before the cs_n fall → host samples 0xC3 on its first received byte.
REQ-040 Async reset mid-byte with 3 bytes queued → in_valid=0 immediately; the next complete byte after a new cs_n fall is the only one queued.

Source files
------------

// File: rtl/spi_cmd_rx_pkg.sv
// Common types and constants for the SPI command receiver, sourced from spi.vh.
`include "spi.vh"

package spi_cmd_rx_pkg;
   localparam int DEFAULT_FIFO_DEPTH  = `SPI_DEFAULT_FIFO_DEPTH;
   localparam int DEFAULT_SYNC_STAGES = `SPI_SYNC_STAGES;
   localparam int BYTE_W              = `SPI_BYTE_W;

   typedef logic [BYTE_W-1:0]         byte_t;
   typedef logic [$clog2(BYTE_W)-1:0] bit_idx_t;

   localparam bit_idx_t LAST_BIT = bit_idx_t'(BYTE_W - 1);
endpackage

// File: rtl/spi_cmd_rx_if.sv
// SPI pins plus the controller-side byte handshake of spi_cmd_rx.
interface spi_cmd_rx_if;
   import spi_cmd_rx_pkg::*;

   logic       spi_sck;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;
   byte_t      tx_byte;
   byte_t      in_byte;
   logic       in_valid;
   logic       next;
   logic       overflow;
   logic       rx_active;
   logic [7:0] ovf_count;

   // Device side.
   modport slave (
      input  spi_sck, spi_cs_n, spi_mosi, tx_byte, next,
      output spi_miso, in_byte, in_valid, overflow, rx_active, ovf_count
   );

   // Host plus controller side.
   modport master (
      output spi_sck, spi_cs_n, spi_mosi, tx_byte, next,
      input  spi_miso, in_byte, in_valid, overflow, rx_active, ovf_count
   );
endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy counter; push and pop may coincide.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   // NOTE: storage has no reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/spi.vh
// Shared SPI receiver constants: default FIFO depth, synchronizer depth and byte width.
`ifndef SPI_VH
`define SPI_VH
`define SPI_DEFAULT_FIFO_DEPTH 16
`define SPI_SYNC_STAGES        2
`define SPI_BYTE_W             8
`endif

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave receiver: synchronizes host pins, assembles bytes into a FIFO, shifts tx_byte out on MISO.
// Define SPI_CMD_RX_OVF_COUNT_EN to build the saturating dropped-byte counter on ovf_count.
module spi_cmd_rx
   import spi_cmd_rx_pkg::*;
#(
   parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic         clk,
   input  logic         reset_n,
   spi_cmd_rx_if.slave  bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
   logic                   sck_prev_q, cs_prev_q;
   logic                   sck_s, mosi_s, cs_s;
   logic                   sck_rise, sck_fall, cs_fall, sel;

   bit_idx_t bit_cnt_q, bit_cnt_d;
   byte_t    rx_q, rx_d;
   byte_t    tx_q, tx_d;
   byte_t    rx_byte;
   logic     push;
   logic     overflow_q, overflow_d;
   logic     drop;

   byte_t         fifo_dout;
   logic          fifo_empty, fifo_full;
   logic [CW-1:0] fifo_count;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];

   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign cs_fall  = ~cs_s & cs_prev_q;
   assign sel      = ~cs_s;
   assign rx_byte  = {rx_q[BYTE_W-2:0], mosi_s};

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      push      = 1'b0;

      if (!sel) begin
         bit_cnt_d = '0;
         rx_d      = '0;
      end else if (sck_rise) begin
         bit_cnt_d = bit_cnt_q + bit_idx_t'(1);
         rx_d      = rx_byte;
         push      = (bit_cnt_q == LAST_BIT);
      end

      // The falling edge right after a byte boundary must not shift away the freshly loaded MSB.
      if (cs_fall || push) begin
         tx_d = bus.tx_byte;
      end else if (sel && sck_fall && bit_cnt_q != '0) begin
         tx_d = {tx_q[BYTE_W-2:0], 1'b0};
      end
   end

   assign drop       = push & fifo_full & ~bus.next;
   assign overflow_d = overflow_q | drop;

   // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b1;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         overflow_q  <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
         sck_prev_q  <= sck_s;
         cs_prev_q   <= cs_s;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         overflow_q  <= overflow_d;
      end
   end

   byte_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (bus.next),
      .din     (rx_byte),
      .dout    (fifo_dout),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign bus.in_valid  = (fifo_count != '0);
   assign bus.in_byte   = fifo_empty ? '0 : fifo_dout;
   assign bus.overflow  = overflow_q;
   assign bus.rx_active = sel;
   assign bus.spi_miso  = sel ? tx_q[BYTE_W-1] : 1'b0;

`ifdef SPI_CMD_RX_OVF_COUNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovf_cnt_q <= '0;
      else          ovf_cnt_q <= ovf_cnt_d;
   end

   assign bus.ovf_count = ovf_cnt_q;
`else
   assign bus.ovf_count = '0;
`endif
endmodule
